memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
// Downstream stage of the per-CPU icache/dcache pair: arbitrates all cache miss traffic
// (instruction reads, data reads, data writes) from NCPU cores onto the single RAM port.
// Owns the iwait/iload and dwait/dload responses the caches consume (cache_control side).
// Priority: data over instruction. Round-robin among CPUs within each class.
// PARAMETERS
// NCPU  2  number of cores; request vectors indexed [NCPU-1:0]; 1..4 supported
// PORTS
// CLK       in   1        clock, all state on posedge
// nRST      in   1        asynchronous active-low reset
// iREN      in   NCPU     icache fill request, per CPU
// iaddr     in   NCPU*32  icache word address, per CPU
// dREN      in   NCPU     dcache read request, per CPU
// dWEN      in   NCPU     dcache write request, per CPU
// daddr     in   NCPU*32  dcache word address, per CPU
// dstore    in   NCPU*32  dcache write data, per CPU
// iwait     out  NCPU     1 = icache must hold; 0 = iload valid this cycle
// iload     out  NCPU*32  instruction word returned
// dwait     out  NCPU     1 = dcache must hold; 0 = access completes this cycle
// dload     out  NCPU*32  data word returned on reads
// ramREN    out  1        RAM read enable
// ramWEN    out  1        RAM write enable
// ramaddr   out  32       RAM address
// ramstore  out  32       RAM write data
// ramload   in   32       RAM read data
// ramstate  in   2        ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
// BEHAVIOUR
// - Reset (async): state=IDLE, grant cleared, irr=drr=0, iwait=dwait='1,
//   iload=dload='0, ramREN=ramWEN=0, ramaddr=ramstore='0.
// - States: IDLE, DSERV, ISERV.
// - IDLE: no RAM enables. At posedge, if any dREN|dWEN: latch CPU k = first requester
//   at or after drr (wrapping), go DSERV; else if any iREN: k = first at or after irr,
//   go ISERV; else stay. Grant index k and op held in regs.
// - DSERV: ramaddr=daddr[k]; dWEN[k] -> ramWEN=1, ramstore=dstore[k]; else ramREN=1.
//   dWEN and dREN both high on same CPU: treated as write.
// - ISERV: ramREN=1, ramaddr=iaddr[k]; ramWEN=0.
// - Completion: cycle with ramstate==ACCESS while serving: the granted wait bit is 0
//   combinationally (iwait[k] or dwait[k]); iload[k]/dload[k]=ramload on reads.
//   Next posedge: IDLE; advance pointer of that class to (k+1) mod NCPU.
// - All non-granted waits stay 1 at all times; loads of non-granted CPUs are 0.
// - BUSY/FREE while serving: hold state, enables, address; wait stays 1.
// - ERROR: treated as BUSY (retry, no completion).
// - Requester drops its request while served (iREN[k]/dREN[k]/dWEN[k] low):
//   enables drop same cycle, return IDLE next posedge, pointer not advanced.
// - Minimum latency: request in IDLE -> RAM enable next cycle -> completion at
//   first ACCESS; a back-to-back grant needs one IDLE cycle between transactions.
// - A new data request never preempts an in-flight instruction fetch; it wins only
//   at the next IDLE arbitration.
// - Reset asserted mid-transaction: enables drop immediately, waits all 1.
// - Address/data widths fixed at 32; no arithmetic beyond pointer wrap mod NCPU.
// TESTING
// - Single ifetch: CPU0 iREN=1 iaddr=0x40, RAM ACCESS after 2 BUSY, ramload=0x8C010004
//   -> ramREN on cycle 1, iwait[0]=0 and iload[0]=0x8C010004 in ACCESS cycle only.
// - D-priority: CPU0 iREN and CPU1 dREN=1 daddr=0x100 same cycle -> DSERV on CPU1
//   first, dwait[1] drops; ISERV for CPU0 follows after one IDLE cycle.
// - Round-robin: both CPUs hold iREN continuously, ACCESS after 1 cycle -> grants
//   alternate 0,1,0,1; neither CPU served twice in a row.
// - Write: CPU1 dWEN=1 daddr=0x200 dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x200,
//   ramstore=0xDEADBEEF; dwait[1]=0 in ACCESS cycle; ramREN stays 0.
// - Abort/ERROR: ramstate=ERROR for 3 cycles -> iwait stays 1, enables held; drop
//   iREN mid-BUSY -> ramREN=0 same cycle, IDLE next, irr unchanged.
// - Reset mid-DSERV: nRST low async -> ramWEN=0 immediately, all waits 1, state IDLE.

Source files
------------

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_if
// Description : Cache-miss request/response bundle for NCPU cores plus the
//               single shared RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if #(
  parameter int NCPU = 2
);
  // cache side
  logic [NCPU-1:0]       iREN;
  logic [NCPU-1:0][31:0] iaddr;
  logic [NCPU-1:0]       dREN;
  logic [NCPU-1:0]       dWEN;
  logic [NCPU-1:0][31:0] daddr;
  logic [NCPU-1:0][31:0] dstore;
  logic [NCPU-1:0]       iwait;
  logic [NCPU-1:0][31:0] iload;
  logic [NCPU-1:0]       dwait;
  logic [NCPU-1:0][31:0] dload;
  // RAM side
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;

  // Arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Cache + RAM environment view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Arbitrates icache/dcache miss traffic from NCPU cores onto one
//               RAM port; data beats instruction, round-robin within a class.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int NCPU = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);

  localparam int                 c_PTR_W      = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST       = c_PTR_W'(NCPU - 1);
  localparam logic [1:0]         c_RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_PTR_W-1:0]   r_grant, w_grant_nxt;
  logic [c_PTR_W-1:0]   r_irr,   w_irr_nxt;
  logic [c_PTR_W-1:0]   r_drr,   w_drr_nxt;
  logic                 r_write, w_write_nxt;

  logic [NCPU-1:0]       w_dreq;
  logic [c_PTR_W-1:0]    w_pick_d;
  logic [c_PTR_W-1:0]    w_pick_i;
  logic [c_PTR_W-1:0]    w_grant_inc;

  logic [NCPU-1:0]       w_iwait;
  logic [NCPU-1:0]       w_dwait;
  logic [NCPU-1:0][31:0] w_iload;
  logic [NCPU-1:0][31:0] w_dload;
  logic                  w_ram_ren;
  logic                  w_ram_wen;
  logic [31:0]           w_ram_addr;
  logic [31:0]           w_ram_store;

  // First requester at or after ptr, wrapping modulo NCPU.
  function automatic logic [c_PTR_W-1:0] f_pick(input logic [NCPU-1:0]    req,
                                                input logic [c_PTR_W-1:0] ptr);
    logic [c_PTR_W-1:0] idx;
    logic               found;
    f_pick = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NCPU; i++) begin
      if (!found && req[idx]) begin
        f_pick = idx;
        found  = 1'b1;
      end
      idx = (idx == c_LAST) ? '0 : idx + 1'b1;
    end
  endfunction

  assign w_dreq      = bus.dREN | bus.dWEN;
  assign w_pick_d    = f_pick(w_dreq, r_drr);
  assign w_pick_i    = f_pick(bus.iREN, r_irr);
  assign w_grant_inc = (r_grant == c_LAST) ? '0 : r_grant + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_irr   <= '0;
      r_drr   <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_irr   <= w_irr_nxt;
      r_drr   <= w_drr_nxt;
      r_write <= w_write_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_irr_nxt   = r_irr;
    w_drr_nxt   = r_drr;
    w_write_nxt = r_write;
    w_iwait     = '1;
    w_dwait     = '1;
    w_iload     = '0;
    w_dload     = '0;
    w_ram_ren   = 1'b0;
    w_ram_wen   = 1'b0;
    w_ram_addr  = '0;
    w_ram_store = '0;

    case (r_state)
      IDLE: begin
        if (|w_dreq) begin
          w_state_nxt = DSERV;
          w_grant_nxt = w_pick_d;
          // simultaneous read+write from one CPU is serviced as a write
          w_write_nxt = bus.dWEN[w_pick_d];
        end else if (|bus.iREN) begin
          w_state_nxt = ISERV;
          w_grant_nxt = w_pick_i;
          w_write_nxt = 1'b0;
        end
      end

      DSERV: begin
        if (w_dreq[r_grant]) begin
          w_ram_addr = bus.daddr[r_grant];
          if (r_write) begin
            w_ram_wen   = 1'b1;
            w_ram_store = bus.dstore[r_grant];
          end else begin
            w_ram_ren   = 1'b1;
          end
          if (bus.ramstate == c_RAM_ACCESS) begin
            w_dwait[r_grant] = 1'b0;
            if (!r_write) begin
              w_dload[r_grant] = bus.ramload;
            end
            w_state_nxt = IDLE;
            w_drr_nxt   = w_grant_inc;
          end
        end else begin
          // requester withdrew: abandon without advancing the pointer
          w_state_nxt = IDLE;
        end
      end

      ISERV: begin
        if (bus.iREN[r_grant]) begin
          w_ram_ren  = 1'b1;
          w_ram_addr = bus.iaddr[r_grant];
          if (bus.ramstate == c_RAM_ACCESS) begin
            w_iwait[r_grant] = 1'b0;
            w_iload[r_grant] = bus.ramload;
            w_state_nxt      = IDLE;
            w_irr_nxt        = w_grant_inc;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.iwait    = w_iwait;
  assign bus.dwait    = w_dwait;
  assign bus.iload    = w_iload;
  assign bus.dload    = w_dload;
  assign bus.ramREN   = w_ram_ren;
  assign bus.ramWEN   = w_ram_wen;
  assign bus.ramaddr  = w_ram_addr;
  assign bus.ramstore = w_ram_store;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Directed vector bench for memory_arbiter with NCPU=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  localparam logic [1:0] c_FREE   = 2'd0;
  localparam logic [1:0] c_BUSY   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ERROR  = 2'd3;

  logic CLK;
  logic nRST;

  memory_arbiter_if #(.NCPU(2)) bus ();

  memory_arbiter #(.NCPU(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [1:0]  iren;
    logic [1:0]  dren;
    logic [1:0]  dwen;
    logic [31:0] da1;
    logic [1:0]  rst;
    logic [31:0] rl;
    logic [1:0]  e_iw;
    logic [1:0]  e_dw;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [63:0] e_iload;
    logic [63:0] e_dload;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(string nm, logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                             logic [31:0] da1, logic [1:0] rst, logic [31:0] rl,
                             logic [1:0] e_iw, logic [1:0] e_dw, logic e_ren, logic e_wen,
                             logic [31:0] e_addr, logic [31:0] e_store,
                             logic [63:0] e_iload, logic [63:0] e_dload);
    vec_t r;
    r.name = nm; r.iren = iren; r.dren = dren; r.dwen = dwen; r.da1 = da1;
    r.rst = rst; r.rl = rl; r.e_iw = e_iw; r.e_dw = e_dw; r.e_ren = e_ren;
    r.e_wen = e_wen; r.e_addr = e_addr; r.e_store = e_store;
    r.e_iload = e_iload; r.e_dload = e_dload;
    return r;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm, vec_t r);
    check({nm, " iwait"},    64'(bus.iwait),    64'(r.e_iw));
    check({nm, " dwait"},    64'(bus.dwait),    64'(r.e_dw));
    check({nm, " ramREN"},   64'(bus.ramREN),   64'(r.e_ren));
    check({nm, " ramWEN"},   64'(bus.ramWEN),   64'(r.e_wen));
    check({nm, " ramaddr"},  64'(bus.ramaddr),  64'(r.e_addr));
    check({nm, " ramstore"}, 64'(bus.ramstore), 64'(r.e_store));
    check({nm, " iload"},    bus.iload,         r.e_iload);
    check({nm, " dload"},    bus.dload,         r.e_dload);
  endtask

  task automatic apply(vec_t r);
    bus.iREN     = r.iren;
    bus.dREN     = r.dren;
    bus.dWEN     = r.dwen;
    bus.daddr[1] = r.da1;
    bus.ramstate = r.rst;
    bus.ramload  = r.rl;
  endtask

  initial begin
    vec_t r;
    // idle-output shorthand: waits high, no enables, zero buses
    tbl.push_back(v("ifetch_idle",  2'b01, 2'b00, 2'b00, 32'h0,   c_BUSY,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("ifetch_busy1", 2'b01, 2'b00, 2'b00, 32'h0,   c_BUSY,   32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("ifetch_busy2", 2'b01, 2'b00, 2'b00, 32'h0,   c_BUSY,   32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("ifetch_acc",   2'b01, 2'b00, 2'b00, 32'h0,   c_ACCESS, 32'h8C010004, 2'b10, 2'b11, 1, 0, 32'h40,  32'h0, {32'h0, 32'h8C010004}, 64'h0));
    tbl.push_back(v("ifetch_done",  2'b00, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("dprio_idle",   2'b01, 2'b10, 2'b00, 32'h100, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("dprio_dacc",   2'b01, 2'b10, 2'b00, 32'h100, c_ACCESS, 32'h12345678, 2'b11, 2'b01, 1, 0, 32'h100, 32'h0, 64'h0, {32'h12345678, 32'h0}));
    tbl.push_back(v("dprio_gap",    2'b01, 2'b00, 2'b00, 32'h100, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("dprio_iacc",   2'b01, 2'b00, 2'b00, 32'h100, c_ACCESS, 32'hA,        2'b10, 2'b11, 1, 0, 32'h40,  32'h0, {32'h0, 32'hA}, 64'h0));
    tbl.push_back(v("rr_idle1",     2'b11, 2'b00, 2'b00, 32'h0,   c_ACCESS, 32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rr_busy1",     2'b11, 2'b00, 2'b00, 32'h0,   c_BUSY,   32'h0,        2'b11, 2'b11, 1, 0, 32'h80,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rr_acc1",      2'b11, 2'b00, 2'b00, 32'h0,   c_ACCESS, 32'hB,        2'b01, 2'b11, 1, 0, 32'h80,  32'h0, {32'hB, 32'h0}, 64'h0));
    tbl.push_back(v("rr_idle0",     2'b11, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rr_busy0",     2'b11, 2'b00, 2'b00, 32'h0,   c_BUSY,   32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rr_acc0",      2'b11, 2'b00, 2'b00, 32'h0,   c_ACCESS, 32'hC,        2'b10, 2'b11, 1, 0, 32'h40,  32'h0, {32'h0, 32'hC}, 64'h0));
    tbl.push_back(v("rr_idle1b",    2'b11, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rr_acc1b",     2'b11, 2'b00, 2'b00, 32'h0,   c_ACCESS, 32'hD,        2'b01, 2'b11, 1, 0, 32'h80,  32'h0, {32'hD, 32'h0}, 64'h0));
    tbl.push_back(v("rr_done",      2'b00, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("wr_idle",      2'b00, 2'b00, 2'b10, 32'h200, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("wr_busy",      2'b00, 2'b00, 2'b10, 32'h200, c_BUSY,   32'h0,        2'b11, 2'b11, 0, 1, 32'h200, 32'hDEADBEEF, 64'h0, 64'h0));
    tbl.push_back(v("wr_acc",       2'b00, 2'b00, 2'b10, 32'h200, c_ACCESS, 32'h5555,     2'b11, 2'b01, 0, 1, 32'h200, 32'hDEADBEEF, 64'h0, 64'h0));
    tbl.push_back(v("wr_done",      2'b00, 2'b00, 2'b00, 32'h200, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rw_idle",      2'b00, 2'b01, 2'b01, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("rw_acc",       2'b00, 2'b01, 2'b01, 32'h0,   c_ACCESS, 32'h6666,     2'b11, 2'b10, 0, 1, 32'h300, 32'h11111111, 64'h0, 64'h0));
    tbl.push_back(v("rw_done",      2'b00, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("err_idle",     2'b01, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("err_1",        2'b01, 2'b00, 2'b00, 32'h0,   c_ERROR,  32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("err_2",        2'b01, 2'b00, 2'b00, 32'h0,   c_ERROR,  32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("err_3",        2'b01, 2'b00, 2'b00, 32'h0,   c_ERROR,  32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("abort_drop",   2'b00, 2'b00, 2'b00, 32'h0,   c_BUSY,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("abort_idle",   2'b11, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("abort_irr",    2'b11, 2'b00, 2'b00, 32'h0,   c_ACCESS, 32'hE,        2'b10, 2'b11, 1, 0, 32'h40,  32'h0, {32'h0, 32'hE}, 64'h0));
    tbl.push_back(v("abort_done",   2'b00, 2'b00, 2'b00, 32'h0,   c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("nopre_idle",   2'b01, 2'b00, 2'b00, 32'h100, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("nopre_busy",   2'b01, 2'b10, 2'b00, 32'h100, c_BUSY,   32'h0,        2'b11, 2'b11, 1, 0, 32'h40,  32'h0, 64'h0, 64'h0));
    tbl.push_back(v("nopre_iacc",   2'b01, 2'b10, 2'b00, 32'h100, c_ACCESS, 32'hF,        2'b10, 2'b11, 1, 0, 32'h40,  32'h0, {32'h0, 32'hF}, 64'h0));
    tbl.push_back(v("nopre_gap",    2'b00, 2'b10, 2'b00, 32'h100, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));
    tbl.push_back(v("nopre_dacc",   2'b00, 2'b10, 2'b00, 32'h100, c_ACCESS, 32'h77,       2'b11, 2'b01, 1, 0, 32'h100, 32'h0, 64'h0, {32'h77, 32'h0}));
    tbl.push_back(v("nopre_done",   2'b00, 2'b00, 2'b00, 32'h100, c_FREE,   32'h0,        2'b11, 2'b11, 0, 0, 32'h0,   32'h0, 64'h0, 64'h0));

    // Reset with requests pending: outputs must stay quiescent
    nRST          = 1'b0;
    bus.iaddr[0]  = 32'h40;
    bus.iaddr[1]  = 32'h80;
    bus.daddr[0]  = 32'h300;
    bus.daddr[1]  = 32'h0;
    bus.dstore[0] = 32'h11111111;
    bus.dstore[1] = 32'hDEADBEEF;
    apply(v("rst", 2'b11, 2'b11, 2'b11, 32'h0, c_ACCESS, 32'h99, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0, 64'h0, 64'h0));
    @(posedge CLK);
    @(negedge CLK);
    check_all("reset", v("rst", 2'b11, 2'b11, 2'b11, 32'h0, c_ACCESS, 32'h99, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0, 64'h0, 64'h0));
    @(posedge CLK);
    #1;
    apply(v("clr", 2'b00, 2'b00, 2'b00, 32'h0, c_FREE, 32'h0, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0, 64'h0, 64'h0));
    nRST = 1'b1;

    foreach (tbl[i]) begin
      r = tbl[i];
      apply(r);
      @(negedge CLK);
      check_all($sformatf("%s[%0d]", r.name, i), r);
      @(posedge CLK);
      #1;
    end

    // Reset asserted mid-write: enables drop immediately, FSM returns to IDLE
    bus.dWEN     = 2'b10;
    bus.daddr[1] = 32'h200;
    bus.ramstate = c_BUSY;
    @(posedge CLK);
    #1;
    check("midrst pre ramWEN", 64'(bus.ramWEN), 64'd1);
    #1 nRST = 1'b0;
    #1;
    check("midrst ramWEN",  64'(bus.ramWEN),  64'd0);
    check("midrst ramREN",  64'(bus.ramREN),  64'd0);
    check("midrst dwait",   64'(bus.dwait),   64'h3);
    check("midrst iwait",   64'(bus.iwait),   64'h3);
    check("midrst ramaddr", 64'(bus.ramaddr), 64'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check("postrst idle ramWEN", 64'(bus.ramWEN), 64'd0);
    @(posedge CLK);
    #1;
    check("postrst regrant ramWEN", 64'(bus.ramWEN),  64'd1);
    check("postrst regrant addr",   64'(bus.ramaddr), 64'h200);
    bus.ramstate = c_ACCESS;
    #1;
    check("postrst dwait", 64'(bus.dwait), 64'h1);
    @(posedge CLK);
    #1;
    bus.dWEN     = 2'b00;
    bus.ramstate = c_FREE;
    @(negedge CLK);
    check("postrst done dwait", 64'(bus.dwait), 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
